// File: rtl/fc_stream_driver.sv
// fc_stream_driver
// Streams a vector from a single-port source RAM (1-cycle read latency) into
// an fc layer over valid/ready, then collects the layer's indexed results and
// writes them straight into a result RAM.
//
// Forward  (mode=0): send IN_SIZE activations, collect OUT_SIZE outputs.
// Backprop (mode=1): send OUT_SIZE errors, collect IN_SIZE input-errors.
//
// Optional feature macro: FC_DRV_TIMEOUT_EN
//   Defined: collect watchdog aborts the pass after TIMEOUT_CYC consecutive
//   beat-less cycles and raises the sticky timeout flag.
//   Undefined: collect waits indefinitely; timeout is tied low.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   start, mode, base_addr     pass request (sampled in IDLE only)
//   busy, done                 pass in progress / one-cycle end pulse
//   err_order, timeout         sticky status, cleared by the next start
//   mem_addr, mem_rdata        source RAM read port
//   lay_in_*                   element stream to the layer
//   lay_forward                direction of the current pass (~mode)
//   lay_out_*                  result stream from the layer
//   res_we, res_addr, res_data result RAM write port
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | waiting for start
// FETCH   | mem_addr presented to the source RAM
// WAIT    | RAM data returning, captured into the layer input
// SEND    | lay_in_valid held until the layer accepts
// COLLECT | accepting indexed results, writing result RAM
// DONE    | one-cycle done pulse
module fc_stream_driver #(
  parameter int IN_SIZE     = 1024,
  parameter int OUT_SIZE    = 10,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 10,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [IDX_W-1:0]  base_addr,
  output logic              busy,
  output logic              done,
  output logic              err_order,
  output logic              timeout,
  output logic [IDX_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lay_in_valid,
  input  logic              lay_in_rdy,
  output logic [DATA_W-1:0] lay_in_data,
  output logic [IDX_W-1:0]  lay_in_idx,
  output logic              lay_forward,
  input  logic              lay_out_valid,
  output logic              lay_out_rdy,
  input  logic [DATA_W-1:0] lay_out_data,
  input  logic [IDX_W-1:0]  lay_out_idx,
  output logic              res_we,
  output logic [IDX_W-1:0]  res_addr,
  output logic [DATA_W-1:0] res_data
);

  // One extra bit so the count can hold lengths equal to 2^IDX_W.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] IN_LEN  = CNT_W'(IN_SIZE);
  localparam logic [CNT_W-1:0] OUT_LEN = CNT_W'(OUT_SIZE);

  if (((1 << IDX_W) < IN_SIZE) || ((1 << IDX_W) < OUT_SIZE) ||
      (IN_SIZE < 1) || (OUT_SIZE < 1) || (TIMEOUT_CYC < 1)) begin : g_bad_param
    $error("fc_stream_driver: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_COLLECT,
    ST_DONE
  } state_t;

  state_t            state, state_nxt;
  logic              mode_q;
  logic [IDX_W-1:0]  base_q;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  n_send, n_recv;
  logic              last_send, last_recv;
  logic              in_hs, out_beat;
  logic              tmo_hit;

  assign n_send    = mode_q ? OUT_LEN : IN_LEN;
  assign n_recv    = mode_q ? IN_LEN  : OUT_LEN;
  assign last_send = (count == n_send - CNT_W'(1));
  assign last_recv = (count == n_recv - CNT_W'(1));
  assign in_hs     = (state == ST_SEND) && lay_in_rdy;
  assign out_beat  = (state == ST_COLLECT) && lay_out_valid;

  assign lay_forward = ~mode_q;
  assign res_addr    = lay_out_idx;
  assign res_data    = lay_out_data;

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    lay_out_rdy = 1'b0;
    res_we      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        busy      = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        busy      = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        busy = 1'b1;
        if (lay_in_rdy) state_nxt = last_send ? ST_COLLECT : ST_FETCH;
      end
      ST_COLLECT: begin
        busy        = 1'b1;
        lay_out_rdy = 1'b1;
        res_we      = lay_out_valid;
        if (lay_out_valid && last_recv) state_nxt = ST_DONE;
        else if (tmo_hit)               state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      mode_q       <= 1'b0;
      base_q       <= '0;
      count        <= '0;
      mem_addr     <= '0;
      lay_in_valid <= 1'b0;
      lay_in_data  <= '0;
      lay_in_idx   <= '0;
      err_order    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q    <= mode;
            base_q    <= base_addr;
            count     <= '0;
            err_order <= 1'b0;
            mem_addr  <= base_addr;
          end
        end
        ST_WAIT: begin
          lay_in_data  <= mem_rdata;
          lay_in_idx   <= count[IDX_W-1:0];
          lay_in_valid <= 1'b1;
        end
        ST_SEND: begin
          if (in_hs) begin
            lay_in_valid <= 1'b0;
            if (last_send) begin
              count <= '0;
            end else begin
              count <= count + CNT_W'(1);
              // Address of the next element; wraps modulo the RAM size.
              mem_addr <= base_q + count[IDX_W-1:0] + IDX_W'(1);
            end
          end
        end
        ST_COLLECT: begin
          if (out_beat) begin
            count <= count + CNT_W'(1);
            if (lay_out_idx != count[IDX_W-1:0]) err_order <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FC_DRV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  // Down-counter of remaining beat-less cycles; reloaded on COLLECT entry
  // and on every accepted beat, fires when a beat-less cycle finds it at 0.
  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_q;

  assign tmo_hit = (state == ST_COLLECT) && !lay_out_valid && (tmo_cnt == '0);
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start) timeout_q <= 1'b0;
      if (in_hs && last_send) begin
        tmo_cnt <= TMO_LOAD;
      end else if (state == ST_COLLECT) begin
        if (lay_out_valid)        tmo_cnt <= TMO_LOAD;
        else if (tmo_cnt != '0)   tmo_cnt <= tmo_cnt - TMO_W'(1);
        if (tmo_hit) timeout_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fc_stream_driver.sv
module tb_fc_stream_driver;

  localparam int IN_SIZE  = 1024;
  localparam int OUT_SIZE = 10;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = 10;
  localparam int DEPTH    = 1 << IDX_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              mode;
  logic [IDX_W-1:0]  base_addr;
  logic              busy, done, err_order, timeout;
  logic [IDX_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              lay_in_valid, lay_in_rdy;
  logic [DATA_W-1:0] lay_in_data;
  logic [IDX_W-1:0]  lay_in_idx;
  logic              lay_forward;
  logic              lay_out_valid, lay_out_rdy;
  logic [DATA_W-1:0] lay_out_data;
  logic [IDX_W-1:0]  lay_out_idx;
  logic              res_we;
  logic [IDX_W-1:0]  res_addr;
  logic [DATA_W-1:0] res_data;

  fc_stream_driver #(
    .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .DATA_W(DATA_W), .IDX_W(IDX_W),
    .TIMEOUT_CYC(4096)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
    .busy(busy), .done(done), .err_order(err_order), .timeout(timeout),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .lay_in_valid(lay_in_valid), .lay_in_rdy(lay_in_rdy),
    .lay_in_data(lay_in_data), .lay_in_idx(lay_in_idx),
    .lay_forward(lay_forward),
    .lay_out_valid(lay_out_valid), .lay_out_rdy(lay_out_rdy),
    .lay_out_data(lay_out_data), .lay_out_idx(lay_out_idx),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] src_ram [DEPTH];
  logic [DATA_W-1:0] res_ram [DEPTH];
  logic [DATA_W-1:0] exp_res [DEPTH];
  logic              res_clr;

  always @(posedge clk) mem_rdata <= src_ram[mem_addr];

  always @(posedge clk) begin
    if (res_clr) begin
      for (int i = 0; i < DEPTH; i++) res_ram[i] <= 32'hA5A5_0000 | DATA_W'(i);
    end else if (res_we) begin
      res_ram[res_addr] <= res_data;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One pass against a transaction-level model: the list of handshakes must
  // equal RAM[(base+i) mod DEPTH] for i < N_SEND, results land at the indices
  // presented, err_order is sticky once any beat k carries index != k.
  // rdy_kind: 0 always ready, 1 ready 1-in-3, 2 random.
  // order_kind: 0 in order, 1 swap beats 2 and 3, 2 random permutation.
  task automatic run_pass(input logic m, input logic [IDX_W-1:0] base,
                          input int rdy_kind, input int order_kind, input int abort_at);
    int n_send, n_recv, pops, hs_cnt, j;
    logic [IDX_W-1:0]  oq_idx [$];
    logic [DATA_W-1:0] oq_dat [$];
    logic [IDX_W-1:0]  hs_idx [$];
    logic [DATA_W-1:0] hs_dat [$];
    logic [IDX_W-1:0]  tmp_i;
    logic [DATA_W-1:0] hold_d;
    logic [IDX_W-1:0]  hold_i;
    bit prev_hs, hold, exp_err, finished, aborted, force_start, r, exp_rdy, acc;

    n_send = m ? OUT_SIZE : IN_SIZE;
    n_recv = m ? IN_SIZE  : OUT_SIZE;
    for (int k = 0; k < n_recv; k++) begin
      oq_idx.push_back(IDX_W'(k));
      oq_dat.push_back($urandom);
    end
    if (order_kind == 1 && n_recv >= 4) begin
      tmp_i = oq_idx[2]; oq_idx[2] = oq_idx[3]; oq_idx[3] = tmp_i;
    end else if (order_kind == 2) begin
      for (int k = n_recv - 1; k > 0; k--) begin
        j = $urandom_range(0, k);
        tmp_i = oq_idx[k]; oq_idx[k] = oq_idx[j]; oq_idx[j] = tmp_i;
      end
    end
    for (int i = 0; i < DEPTH; i++) exp_res[i] = 32'hA5A5_0000 | DATA_W'(i);

    @(negedge clk); res_clr = 1'b1;
    @(negedge clk); res_clr = 1'b0;
    start = 1'b1; mode = m; base_addr = base;

    pops = 0; hs_cnt = 0;
    prev_hs = 0; hold = 0; exp_err = 0; finished = 0; aborted = 0; force_start = 0;
    hold_d = '0; hold_i = '0;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      @(negedge clk);
      check("timeout", timeout, 0);
      check("err_order", err_order, exp_err);
      if (prev_hs) check("valid_drop", lay_in_valid, 0);
      if (hold) begin
        check("hold_valid", lay_in_valid, 1);
        check("hold_data", lay_in_data, hold_d);
        check("hold_idx", lay_in_idx, hold_i);
      end
      if (done) begin
        check("busy_at_done", busy, 0);
        check("beats_before_done", pops, n_recv);
        finished = 1;
        break;
      end
      check("busy", busy, 1);
      check("lay_forward", lay_forward, !m);
      if (abort_at >= 0 && hs_cnt == abort_at && lay_in_valid) begin
        rst_n = 1'b0; lay_in_rdy = 1'b0; lay_out_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_valid", lay_in_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        aborted = 1;
        break;
      end

      start     = force_start || ($urandom_range(0, 7) == 0);
      mode      = 1'($urandom);
      base_addr = IDX_W'($urandom);
      case (rdy_kind)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom);
      endcase
      lay_in_rdy = r;
      prev_hs = lay_in_valid && r;
      hold    = lay_in_valid && !r;
      hold_d  = lay_in_data;
      hold_i  = lay_in_idx;
      if (prev_hs) begin
        hs_idx.push_back(lay_in_idx);
        hs_dat.push_back(lay_in_data);
        hs_cnt++;
      end

      if (oq_idx.size() > 0 && $urandom_range(0, 3) != 0) begin
        lay_out_valid = 1'b1;
        lay_out_idx   = oq_idx[0];
        lay_out_data  = oq_dat[0];
      end else begin
        lay_out_valid = 1'b0;
        lay_out_idx   = IDX_W'($urandom);
        lay_out_data  = $urandom;
      end
      #1;
      // Collection starts the cycle after the last input handshake.
      exp_rdy = (hs_cnt == n_send) && !prev_hs && (pops < n_recv);
      check("out_rdy", lay_out_rdy, exp_rdy);
      acc = lay_out_valid && exp_rdy;
      check("res_we", res_we, acc);
      if (acc) begin
        check("res_addr", res_addr, oq_idx[0]);
        check("res_data", res_data, oq_dat[0]);
        exp_res[oq_idx[0]] = oq_dat[0];
        if (int'(oq_idx[0]) != pops) exp_err = 1;
        void'(oq_idx.pop_front());
        void'(oq_dat.pop_front());
        pops++;
        if (pops == n_recv) force_start = 1;
      end
    end

    if (!finished && !aborted) check("pass_cycle_budget", 0, 1);
    if (finished) begin
      // start was held high through the DONE cycle; it must be ignored.
      @(negedge clk);
      check("start_in_done_ignored", busy, 0);
      check("single_done", done, 0);
      start = 1'b0; lay_out_valid = 1'b0; lay_in_rdy = 1'b0;
      check("hs_count", hs_idx.size(), n_send);
      for (int i = 0; i < hs_idx.size() && i < n_send; i++) begin
        check("hs_idx", hs_idx[i], i);
        check("hs_data", hs_dat[i], src_ram[(int'(base) + i) % DEPTH]);
      end
      for (int i = 0; i < DEPTH; i++) check("res_ram", res_ram[i], exp_res[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0;
    lay_in_rdy = 1'b0; lay_out_valid = 1'b1; lay_out_data = '1; lay_out_idx = '1;
    res_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) src_ram[i] = DATA_W'(i) << 16;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_valid", lay_in_valid, 0);
    check("rst_out_rdy", lay_out_rdy, 0);
    check("rst_res_we", res_we, 0);
    check("rst_err_order", err_order, 0);
    check("rst_timeout", timeout, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_in_idx", lay_in_idx, 0);
    check("rst_in_data", lay_in_data, 0);
    rst_n = 1'b1; lay_out_valid = 1'b0;
    @(negedge clk);

    run_pass(1'b0, '0, 0, 0, -1);                        // forward, ideal layer
    for (int i = 0; i < DEPTH; i++) src_ram[i] = $urandom;
    run_pass(1'b0, IDX_W'($urandom), 1, 0, -1);          // 1-in-3 back-pressure
    run_pass(1'b1, IDX_W'(1020), 2, 0, -1);              // backprop with wrap
    run_pass(1'b0, '0, 0, 1, -1);                        // out-of-order results
    run_pass(1'b0, '0, 0, 0, 500);                       // reset mid-send
    run_pass(1'b0, '0, 0, 0, -1);                        // resend from idx 0
    run_pass(1'b0, IDX_W'($urandom), 2, 2, -1);          // random order
    run_pass(1'b1, IDX_W'($urandom), 2, 2, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_stream_driver.md
Name: fc_stream_driver

Overview:
- Sequencer that feeds a vector from a single-port, 1-cycle-latency RAM into an fc layer over a valid/ready handshake, then collects the layer's indexed results into a result RAM.
- Replaces hand-written bench/top-level feeding loops.
- Parametrised in vector sizes and data width.
- Supports forward mode (stream IN_SIZE activations, collect OUT_SIZE outputs) and backprop mode (stream OUT_SIZE errors, collect IN_SIZE input-errors).

Parameters:
IN_SIZE, 1024, layer input vector length
OUT_SIZE, 10, layer output vector length
DATA_W, 32, sample width (Q16.16 passed through untouched)
IDX_W, 10, index/address width; must satisfy 2^IDX_W >= max(IN_SIZE, OUT_SIZE)
TIMEOUT_CYC, 4096, collect watchdog limit (only with FC_DRV_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin a pass; sampled only in IDLE
mode  in  1  0=forward, 1=backprop; latched with start
base_addr  in  IDX_W  source RAM start address; latched with start
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at pass end
err_order  out  1  sticky, out-of-order result index seen; cleared on next start
timeout  out  1  sticky watchdog abort (feature only, else tied 0)
mem_addr  out  IDX_W  source RAM address
mem_rdata  in  DATA_W  source RAM data, valid one cycle after mem_addr
lay_in_valid  out  1  element valid to layer
lay_in_rdy  in  1  layer accepts element
lay_in_data  out  DATA_W  element to layer
lay_in_idx  out  IDX_W  element index
lay_forward  out  1  ~latched mode
lay_out_valid  in  1  layer result valid
lay_out_rdy  out  1  driver accepts result
lay_out_data  in  DATA_W  result value
lay_out_idx  in  IDX_W  result index
res_we  out  1  result RAM write strobe
res_addr  out  IDX_W  result RAM address
res_data  out  DATA_W  result RAM data

Behaviour:
- Reset: state IDLE; busy, done, lay_in_valid, lay_out_rdy, res_we, err_order and timeout = 0; mem_addr, lay_in_idx and lay_in_data = 0. Reset mid-pass aborts immediately. No done pulse.
- Lengths: N_SEND = mode ? OUT_SIZE : IN_SIZE. N_RECV = mode ? IN_SIZE : OUT_SIZE.
- IDLE: on start=1, latch mode and base_addr, clear count and sticky flags, set busy, go FETCH.
- FETCH (1 cycle):
  - mem_addr = base + count, mod 2^IDX_W (wraps).
  - Go WAIT.
- WAIT (1 cycle):
  - Register mem_rdata into lay_in_data.
  - lay_in_idx = count.
  - Assert lay_in_valid. Go SEND.
- SEND:
  - Hold lay_in_valid, data and idx stable until lay_in_rdy=1 is sampled.
  - On handshake: drop valid next cycle.
  - If count == N_SEND-1: clear count, go COLLECT. Else count+1, go FETCH.
  - Throughput: 3 cycles per element minimum.
- COLLECT:
  - lay_out_rdy = 1.
  - Each cycle with lay_out_valid=1: res_we=1 with res_addr=lay_out_idx and res_data=lay_out_data, combinational same-cycle write.
  - If lay_out_idx != count, set err_order. The write still uses the received index.
  - count increments per beat.
  - After N_RECV beats: go DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Output beats arriving outside COLLECT are not accepted (lay_out_rdy=0).
- start while busy is ignored.
- start in the same cycle as DONE is ignored. Accepted no earlier than the following IDLE cycle.
- lay_forward is driven from the latched mode for the whole pass.

Optional Feature:
- FC_DRV_TIMEOUT_EN defined:
  - Idle counter runs in COLLECT, reset on every accepted beat.
  - At TIMEOUT_CYC consecutive cycles without a beat: set timeout, go DONE (done pulse still issued). Partial results remain in the result RAM.
- Not defined:
  - No counter; COLLECT waits indefinitely.
  - timeout is constant 0.

Test Plan:
- Forward, base_addr=0, RAM[i]=i<<16, lay_in_rdy always 1 -> lay_in_idx 0..1023 with matching data, exactly 1024 handshakes; the model returns idx 0..9 -> res RAM 0..9 written, one done pulse, err_order=0.
- Back-pressure: lay_in_rdy toggles 1-in-3 -> lay_in_data and lay_in_idx stable while valid&&!rdy; no element lost or duplicated.
- Backprop, mode=1, base_addr=1020 -> 10 elements read from addresses 1020..1023 then 0..5 (wrap), lay_forward=0; collect 1024 results, then done.
- Out-of-order results, idx sequence 0,1,3,2,4..9 -> err_order=1 after the third beat, all 10 writes land at the received indices, done still pulses.
- rst_n=0 mid-SEND at element 500 -> next cycle lay_in_valid=0, busy=0, no done; a new start resends from idx 0.
- With FC_DRV_TIMEOUT_EN and TIMEOUT_CYC=16: layer returns 3 results then stalls -> timeout=1 and done 16 cycles after the third beat.
